// File: rtl/pipe_reg_pkg.sv
// Purpose: shared constants, clog2 helper and count type for pipe_reg.
// Latency: n/a (types and constants only).
// Backpressure: n/a. PIPE_REG_SKID_EN widens the count for the two skid entries.
package pipe_reg_pkg;

  localparam int PIPE_REG_DEF_WIDTH = 3;
  localparam int PIPE_REG_DEF_DEPTH = 2;

  // Extra occupancy slots on top of DEPTH, plus one for the zero state.
`ifdef PIPE_REG_SKID_EN
  localparam int PIPE_REG_CNT_EXTRA = 3;
`else
  localparam int PIPE_REG_CNT_EXTRA = 1;
`endif

  // Ceiling log2 usable in constant expressions (clog2_f(1) == 0).
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy count type for the default depth.
  typedef logic [clog2_f(PIPE_REG_DEF_DEPTH + PIPE_REG_CNT_EXTRA)-1:0] count_t;

endpackage

// File: rtl/pipe_reg_stage.sv
// Purpose: one elastic register stage (valid + data) of the pipe_reg pipeline.
// Latency: 1 cycle from in_vld/in_dat to v/d.
// Backpressure: advances when downstream advances or when empty (bubble collapse).
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int              WIDTH   = PIPE_REG_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             down_adv,
  output logic             adv,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // An empty stage can always take a new item, even if downstream is stalled.
  assign adv = down_adv | ~v_q;
  assign v   = v_q;
  assign d   = d_q;

  // Next state: flush clears, otherwise shift on advance; data loads only for valid items.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
      d_d = RST_VAL;
    end else if (adv) begin
      v_d = in_vld;
      if (in_vld) d_d = in_dat;
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Purpose: DEPTH-stage elastic register pipeline with flush and occupancy count (optional skid: PIPE_REG_SKID_EN).
// Latency: DEPTH cycles (DEPTH+1 with PIPE_REG_SKID_EN); throughput 1 item/cycle.
// Backpressure: combinational ready chain from q_ready; with PIPE_REG_SKID_EN ns_ready is registered (skid not full).
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH   = PIPE_REG_DEF_WIDTH,
  parameter int               DEPTH   = PIPE_REG_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int              CNT_W   = clog2_f(DEPTH + PIPE_REG_CNT_EXTRA)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic [WIDTH-1:0] ns,
  input  logic             ns_valid,
  output logic             ns_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CNT_W-1:0] count
);

  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_params
    $error("pipe_reg: WIDTH and DEPTH must both be >= 1");
  end

  // Feed into stage 0 (directly from ns, or from the skid head).
  logic             s0_vld;
  logic [WIDTH-1:0] s0_dat;
  logic             s0_adv;
  logic             in_xfer, out_xfer;

  assign in_xfer  = ns_valid & ns_ready;
  assign out_xfer = q_valid & q_ready;

  // Stage chain; each stage keeps its own adv net so the ready chain has no self-loop.
  for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
    logic             in_vld_w;
    logic [WIDTH-1:0] in_dat_w;
    logic             down_adv_w;
    logic             adv_w;
    logic             v_w;
    logic [WIDTH-1:0] d_w;

    if (k == 0) begin : g_first
      assign in_vld_w = s0_vld;
      assign in_dat_w = s0_dat;
      assign s0_adv   = adv_w;
    end else begin : g_mid
      assign in_vld_w = gen_stage[k-1].v_w;
      assign in_dat_w = gen_stage[k-1].d_w;
    end

    if (k == DEPTH - 1) begin : g_last
      assign down_adv_w = q_ready;
      assign q          = d_w;
      assign q_valid    = v_w;
    end else begin : g_inner
      assign down_adv_w = gen_stage[k+1].adv_w;
    end

    pipe_reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .clrn     (clrn),
      .flush    (flush),
      .in_vld   (in_vld_w),
      .in_dat   (in_dat_w),
      .down_adv (down_adv_w),
      .adv      (adv_w),
      .v        (v_w),
      .d        (d_w)
    );
  end

`ifdef PIPE_REG_SKID_EN
  // Two-entry skid ahead of stage 0; entry 0 is the head.
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic [WIDTH-1:0] skid_dat_q [2];
  logic [WIDTH-1:0] skid_dat_d [2];
  logic             skid_push, skid_pop;

  // Ready comes straight from a register, cutting the path from q_ready.
  assign ns_ready  = (skid_cnt_q != 2'd2);
  assign s0_vld    = (skid_cnt_q != 2'd0);
  assign s0_dat    = skid_dat_q[0];
  assign skid_push = in_xfer;
  assign skid_pop  = s0_vld & s0_adv;

  // Skid next state: pop shifts entry 1 to head, push writes the first free slot.
  always_comb begin
    skid_cnt_d    = skid_cnt_q;
    skid_dat_d[0] = skid_dat_q[0];
    skid_dat_d[1] = skid_dat_q[1];
    if (flush) begin
      skid_cnt_d    = 2'd0;
      skid_dat_d[0] = RST_VAL;
      skid_dat_d[1] = RST_VAL;
    end else begin
      if (skid_pop) skid_dat_d[0] = skid_dat_q[1];
      if (skid_push) begin
        if (skid_cnt_q == 2'd0 || (skid_cnt_q == 2'd1 && skid_pop)) skid_dat_d[0] = ns;
        else                                                         skid_dat_d[1] = ns;
      end
      skid_cnt_d = skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

  // Skid registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      skid_cnt_q    <= 2'd0;
      skid_dat_q[0] <= RST_VAL;
      skid_dat_q[1] <= RST_VAL;
    end else begin
      skid_cnt_q    <= skid_cnt_d;
      skid_dat_q[0] <= skid_dat_d[0];
      skid_dat_q[1] <= skid_dat_d[1];
    end
  end
`else
  assign s0_vld   = ns_valid;
  assign s0_dat   = ns;
  assign ns_ready = s0_adv;
`endif

  logic [CNT_W-1:0] count_q, count_d;

  assign count = count_q;

  // Occupancy tracks external transfers; flush empties everything.
  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Purpose: self-checking bench for pipe_reg (WIDTH=3, DEPTH=2), vector table plus hand sequences.
// Latency: expects DEPTH (DEPTH+1 with PIPE_REG_SKID_EN) from accept to q_valid.
// Backpressure: exercises stalls, bubbles, flush and the ready path.
module tb_pipe_reg;
  import pipe_reg_pkg::*;

  localparam int WIDTH = 3;
  localparam int DEPTH = 2;
`ifdef PIPE_REG_SKID_EN
  localparam int MAX_CNT = DEPTH + 2;
  localparam int LAT     = DEPTH + 1;
`else
  localparam int MAX_CNT = DEPTH;
  localparam int LAT     = DEPTH;
`endif

  logic             clk = 1'b0;
  logic             clrn, flush, ns_valid, ns_ready, q_valid, q_ready;
  logic [WIDTH-1:0] ns, q;
  count_t           count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_reg #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (3'b000)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .flush    (flush),
    .ns       (ns),
    .ns_valid (ns_valid),
    .ns_ready (ns_ready),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .count    (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Occupancy must stay within 0..MAX_CNT (an underflow would wrap above MAX_CNT).
  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      tests++;
      if (count > count_t'(MAX_CNT)) begin
        fails++;
        $display("FAIL count_bound: got %0d, max %0d", count, MAX_CNT);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       clrn, flush, nv;
    logic [2:0] ns;
    logic       qr, chk, rdy;
    logic [2:0] q;
    logic       qv;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, f, nv, input logic [2:0] n, input logic qr,
                     input logic chk, rdy, input logic [2:0] eq, input logic eqv, input int ec);
    vec_t v;
    v.clrn = c; v.flush = f; v.nv = nv; v.ns = n; v.qr = qr;
    v.chk = chk; v.rdy = rdy; v.q = eq; v.qv = eqv; v.cnt = ec;
    vecs.push_back(v);
  endtask

  int acc, n, lat;

  initial begin
    clrn = 1'b0; flush = 1'b0; ns_valid = 1'b0; ns = '0; q_ready = 1'b0;

    // Inputs are applied for one cycle; expectations are the outputs seen during that cycle.
    //   clrn flush nv  ns   qr  chk rdy q    qv cnt
    add(0, 0, 1, 3'd5, 1, 0, 0, 3'd0, 0, 0); // reset edge 1, outputs unknown before it
    add(0, 0, 1, 3'd5, 1, 1, 1, 3'd0, 0, 0); // reset edge 2
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd0, 0, 0); // released, ready
`ifndef PIPE_REG_SKID_EN
    // streaming 1..4
    add(1, 0, 1, 3'd1, 1, 1, 1, 3'd0, 0, 0);
    add(1, 0, 1, 3'd2, 1, 1, 1, 3'd0, 0, 1);
    add(1, 0, 1, 3'd3, 1, 1, 1, 3'd1, 1, 2);
    add(1, 0, 1, 3'd4, 1, 1, 1, 3'd2, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd3, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd4, 1, 1);
    add(1, 0, 0, 3'd0, 0, 1, 1, 3'd4, 0, 0); // empty: q holds last value
    // backpressure 5,6,7
    add(1, 0, 1, 3'd5, 0, 1, 1, 3'd4, 0, 0);
    add(1, 0, 1, 3'd6, 0, 1, 1, 3'd4, 0, 1);
    add(1, 0, 1, 3'd7, 0, 1, 0, 3'd5, 1, 2);
    add(1, 0, 1, 3'd7, 0, 1, 0, 3'd5, 1, 2);
    add(1, 0, 1, 3'd7, 1, 1, 1, 3'd5, 1, 2); // 7 enters as 5 leaves
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd6, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd7, 1, 1);
    add(1, 0, 0, 3'd0, 0, 1, 1, 3'd7, 0, 0);
    // bubble collapse
    add(1, 0, 1, 3'd1, 0, 1, 1, 3'd7, 0, 0);
    add(1, 0, 0, 3'd0, 0, 1, 1, 3'd7, 0, 1);
    add(1, 0, 1, 3'd2, 0, 1, 1, 3'd1, 1, 1);
    add(1, 0, 0, 3'd0, 0, 1, 0, 3'd1, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd1, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd2, 1, 1);
    add(1, 0, 0, 3'd0, 0, 1, 1, 3'd2, 0, 0);
    // flush mid-stream holding 3,4 while 6 is offered
    add(1, 0, 1, 3'd3, 0, 1, 1, 3'd2, 0, 0);
    add(1, 0, 1, 3'd4, 0, 1, 1, 3'd2, 0, 1);
    add(1, 1, 1, 3'd6, 1, 1, 1, 3'd3, 1, 2);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd0, 0, 0);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd0, 0, 0);
    add(1, 0, 1, 3'd7, 1, 1, 1, 3'd0, 0, 0);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd0, 0, 1);
    add(1, 0, 0, 3'd0, 1, 1, 1, 3'd7, 1, 1); // next item out is 7, never 6
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clrn = vecs[i].clrn; flush = vecs[i].flush; ns_valid = vecs[i].nv;
      ns = vecs[i].ns; q_ready = vecs[i].qr;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d.ns_ready", i), ns_ready, vecs[i].rdy);
        check($sformatf("vec%0d.q", i), q, vecs[i].q);
        check($sformatf("vec%0d.q_valid", i), q_valid, vecs[i].qv);
        check($sformatf("vec%0d.count", i), count, vecs[i].cnt);
      end
    end

`ifndef PIPE_REG_SKID_EN
    // Full pipe: ns_ready follows q_ready combinationally within the cycle.
    @(negedge clk); flush = 1'b0; clrn = 1'b1; ns_valid = 1'b1; ns = 3'd1; q_ready = 1'b0;
    @(negedge clk); ns = 3'd2;
    @(negedge clk); ns_valid = 1'b0; #1;
    check("full.ns_ready", ns_ready, 1'b0);
    check("full.count", count, 2);
    q_ready = 1'b1; #1;
    check("full.ready_follows_hi", ns_ready, 1'b1);
    q_ready = 1'b0; #1;
    check("full.ready_follows_lo", ns_ready, 1'b0);
    check("full.q", q, 3'd1);
    @(negedge clk); q_ready = 1'b1; #1;
    check("drain.q0", q, 3'd1);
    @(negedge clk); #1;
    check("drain.q1", q, 3'd2);
    check("drain.qv1", q_valid, 1'b1);
    @(negedge clk); #1;
    check("drain.empty_qv", q_valid, 1'b0);
    check("drain.empty_cnt", count, 0);
`else
    // Skid: stalled output with continuous offers accepts exactly DEPTH+2 items.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ns_valid = 1'b1; q_ready = 1'b0; ns = 3'(acc + 1); #1;
      if (ns_ready) acc++;
    end
    @(negedge clk); ns_valid = 1'b0; #1;
    check("skid.accepted", acc, 4);
    check("skid.count", count, 4);
    check("skid.ns_ready", ns_ready, 1'b0);
    q_ready = 1'b1; #1;
    check("skid.ready_registered", ns_ready, 1'b0);
    n = 0;
    for (int c = 0; c < 12 && n < 4; c++) begin
      if (q_valid && q_ready) begin
        check($sformatf("skid.out%0d", n), q, n + 1);
        n++;
      end
      @(negedge clk); #1;
    end
    check("skid.out_count", n, 4);
`endif

    // Single-item latency with no backpressure, bounded wait.
    @(negedge clk); ns_valid = 1'b1; ns = 3'd5; q_ready = 1'b1;
    @(posedge clk); #1; ns_valid = 1'b0;
    lat = 1;
    while (!q_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, LAT);
    check("latency.q", q, 3'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
